mux4_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 4:1 single-bit select channel. Four requesters compete for the channel. The block grants one requester at a time, drives the 2-bit mux select and a one-hot grant, and registers the selected data bit as the channel output. It sits between the requesting sources and the downstream consumer of the muxed bit, and is the only block that drives the channel select.

---
 rtl/mux4_arb_pkg.sv | 19 +
 rtl/rr_pick4.sv | 28 ++
 rtl/mux4_rr_arbiter.sv | 70 +++++++
 tb/tb_mux4_rr_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// rtl/mux4_arb_pkg.sv - shared constants, state type and helpers for the 4:1 round-robin arbiter
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin pick: first set request at or after ptr
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   win
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     off;

  // Rotate so ptr lands at bit 0, fixed-priority encode, then add ptr back.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[NUM_REQ-1:0];
    off = 2'd0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
    any = |req;
    win = off + ptr;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving the shared 4:1 select and registered data bit
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] d,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   sel,
  output logic               o,
  output logic               valid
);

  localparam int CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_t       state;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] ptr;
  logic             arb_now;
  logic             any;
  logic [IDX_W-1:0] win;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .any (any),
    .win (win)
  );

  // Re-arbitrate when idle, when the owner lets go, or when its hold window is used up.
  always_comb begin
    arb_now = (state == IDLE) || !req[sel] || (count == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      sel   <= '0;
      ptr   <= '0;
      count <= '0;
      o     <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= (state == BUSY);
      if (state == BUSY) begin
        o <= d[sel];
      end
      if (arb_now) begin
        if (any) begin
          state <= BUSY;
          grant <= onehot4(win);
          sel   <= win;
          count <= '0;
          ptr   <= win + 2'd1;
        end else begin
          state <= IDLE;
          grant <= '0;
        end
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

  typedef struct {
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       o;
    logic       valid;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] grant2, grant8;
  logic [1:0] sel2, sel8;
  logic       o2, o8, valid2, valid8;

  int n_pass;
  int n_total;

  vec_t tbl[21];

  mux4_rr_arbiter #(.HOLD_MAX(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .d     (d),
    .grant (grant2),
    .sel   (sel2),
    .o     (o2),
    .valid (valid2)
  );

  mux4_rr_arbiter #(.HOLD_MAX(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .d     (d),
    .grant (grant8),
    .sel   (sel8),
    .o     (o8),
    .valid (valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    d     = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] p_d;
    logic [1:0] p_sel;
    logic       p_busy;
    logic [3:0] p_req;
    int         wait_cnt[4];

    n_pass  = 0;
    n_total = 0;

    // HOLD_MAX=2 vectors: rotation, hand-off, idle and ptr-ordered restart
    tbl[0]  = '{4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b0, 1'b1};
    tbl[2]  = '{4'b1111, 4'b1010, 4'b0010, 2'd1, 1'b0, 1'b1};
    tbl[3]  = '{4'b1111, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[4]  = '{4'b1111, 4'b1010, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[5]  = '{4'b1111, 4'b1010, 4'b0100, 2'd2, 1'b0, 1'b1};
    tbl[6]  = '{4'b1111, 4'b1010, 4'b1000, 2'd3, 1'b0, 1'b1};
    tbl[7]  = '{4'b1111, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[8]  = '{4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[9]  = '{4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b0, 1'b1};
    tbl[10] = '{4'b1010, 4'b1010, 4'b0010, 2'd1, 1'b0, 1'b1};
    tbl[11] = '{4'b1010, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[12] = '{4'b1000, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[13] = '{4'b1000, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[14] = '{4'b0010, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[15] = '{4'b0010, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[16] = '{4'b0000, 4'b1010, 4'b0000, 2'd1, 1'b1, 1'b1};
    tbl[17] = '{4'b0000, 4'b1010, 4'b0000, 2'd1, 1'b1, 1'b0};
    tbl[18] = '{4'b0001, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[19] = '{4'b0101, 4'b1010, 4'b0001, 2'd0, 1'b0, 1'b1};
    tbl[20] = '{4'b0101, 4'b1010, 4'b0100, 2'd2, 1'b0, 1'b1};

    do_reset();
    check("reset grant", 32'(grant2), 32'h0);
    check("reset sel", 32'(sel2), 32'h0);
    check("reset o", 32'(o2), 32'h0);
    check("reset valid", 32'(valid2), 32'h0);
    check("reset grant8", 32'(grant8), 32'h0);

    for (int i = 0; i < 21; i++) begin
      req = tbl[i].req;
      d   = tbl[i].d;
      step();
      check($sformatf("row%0d grant", i), 32'(grant2), 32'(tbl[i].grant));
      check($sformatf("row%0d sel", i), 32'(sel2), 32'(tbl[i].sel));
      check($sformatf("row%0d o", i), 32'(o2), 32'(tbl[i].o));
      check($sformatf("row%0d valid", i), 32'(valid2), 32'(tbl[i].valid));
    end

    // HOLD_MAX=8: a lone requester keeps the grant through expiry with no bubble
    do_reset();
    req = 4'b0100;
    d   = 4'b0100;
    step();
    check("h8 first grant", 32'(grant8), 32'h4);
    check("h8 first sel", 32'(sel8), 32'd2);
    check("h8 first valid", 32'(valid8), 32'd0);
    for (int c = 2; c <= 16; c++) begin
      step();
      check($sformatf("h8 c%0d grant", c), 32'(grant8), 32'h4);
      check($sformatf("h8 c%0d valid", c), 32'(valid8), 32'd1);
      check($sformatf("h8 c%0d o", c), 32'(o8), 32'd1);
    end

    // Competing requester: source 0 wins, holds exactly 8 cycles, then source 2
    req = 4'b0101;
    for (int c = 17; c <= 25; c++) begin
      step();
      check($sformatf("h8 c%0d grant", c), 32'(grant8), (c < 25) ? 32'h1 : 32'h4);
      check($sformatf("h8 c%0d valid", c), 32'(valid8), 32'd1);
    end

    // Asynchronous reset in the middle of a grant
    req = 4'b1000;
    d   = 4'b1000;
    step();
    step();
    check("pre-rst grant8", 32'(grant8), 32'h8);
    check("pre-rst o8", 32'(o8), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid-rst grant8", 32'(grant8), 32'h0);
    check("mid-rst sel8", 32'(sel8), 32'h0);
    check("mid-rst o8", 32'(o8), 32'h0);
    check("mid-rst valid8", 32'(valid8), 32'h0);
    check("mid-rst grant2", 32'(grant2), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b1001;
    step();
    check("post-rst grant8", 32'(grant8), 32'h1);
    check("post-rst sel8", 32'(sel8), 32'd0);
    check("post-rst grant2", 32'(grant2), 32'h1);

    // Randomized traffic on HOLD_MAX=2: structural, data and fairness properties
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      d      = 4'($urandom);
      p_d    = d;
      p_req  = req;
      p_sel  = sel2;
      p_busy = (grant2 != 4'b0000);
      step();
      check("rand onehot", 32'($onehot0(grant2)), 32'd1);
      if (grant2 != 4'b0000) check("rand sel", 32'(grant2), 32'(4'b0001 << sel2));
      check("rand valid", 32'(valid2), 32'(p_busy));
      if (p_busy) check("rand o", 32'(o2), 32'(p_d[p_sel]));
      for (int i = 0; i < 4; i++) begin
        if (p_req[i] && !grant2[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > 6) begin
          check($sformatf("rand wait src%0d", i), 32'(wait_cnt[i]), 32'd6);
          wait_cnt[i] = 0;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
